// File: rtl/fifo_rd_sequencer_if.sv
// Signal bundle between the FIFO read-side sequencer, the FIFO read port and the downstream consumer.
interface fifo_rd_sequencer_if #(
    parameter int WIDTHR = 4,
    parameter int PACK   = 2,
    parameter int CNTW   = 16
);
    logic                     Enable;
    logic                     Flush;
    logic [WIDTHR-1:0]        FifoQ;
    logic                     FifoEmpty;
    logic                     FifoRdEn;
    logic                     FifoRPReset;
    logic [WIDTHR*PACK-1:0]   OutData;
    logic                     OutValid;
    logic                     OutReady;
    logic                     Busy;
    logic [CNTW-1:0]          BeatCount;

    modport slave (
        input  Enable, Flush, FifoQ, FifoEmpty, OutReady,
        output FifoRdEn, FifoRPReset, OutData, OutValid, Busy, BeatCount
    );

    modport master (
        output Enable, Flush, FifoQ, FifoEmpty, OutReady,
        input  FifoRdEn, FifoRPReset, OutData, OutValid, Busy, BeatCount
    );
endinterface

// File: rtl/fifo_rd_sequencer.sv
// Read-clock-domain controller: drains the FIFO, packs PACK words per output beat and
// owns the read-pointer reset used to flush stale data.
module fifo_rd_sequencer #(
    parameter int WIDTHR = 4,
    parameter int PACK   = 2,
    parameter int CNTW   = 16
) (
    input  logic               Clock,
    input  logic               nReset,
    fifo_rd_sequencer_if.slave bus
);
    localparam int CW = $clog2(PACK + 1);
    localparam int AW = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                asm_cnt_q, asm_cnt_d;
    logic                         inflight_q, inflight_d;
    logic                         fl_cnt_q, fl_cnt_d;
    logic                         rpreset_q, rpreset_d;
    logic [PACK-1:0][WIDTHR-1:0]  asm_data_q, asm_data_d;
    logic [WIDTHR*PACK-1:0]       out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic [CNTW-1:0]              beat_cnt_q, beat_cnt_d;

    logic                         discard;
    logic                         land;
    logic                         out_free;
    logic                         beat_done;
    logic                         rd_en;
    logic [AW-1:0]                asm_fill;
    logic [AW-1:0]                occupancy;

    always_comb begin
        discard   = bus.Flush || (state_q == FLUSH);
        land      = inflight_q && !discard;
        out_free  = !out_valid_q || bus.OutReady;
        asm_fill  = {1'b0, asm_cnt_q} + AW'(land);
        beat_done = !discard && out_free && (asm_fill == AW'(PACK));
        // A beat leaving the assembly this cycle frees every slot, which keeps reads back-to-back.
        occupancy = beat_done ? '0 : ({1'b0, asm_cnt_q} + AW'(inflight_q));
        rd_en     = (state_q == RUN) && !bus.FifoEmpty && !bus.Flush &&
                    (occupancy < AW'(PACK));
    end

    always_comb begin
        asm_data_d = asm_data_q;
        for (int i = 0; i < PACK; i++) begin
            if (land && (asm_cnt_q == CW'(i))) asm_data_d[i] = bus.FifoQ;
        end

        if (discard || beat_done) asm_cnt_d = '0;
        else                      asm_cnt_d = asm_fill[CW-1:0];

        inflight_d  = rd_en;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_valid_q && bus.OutReady) out_valid_d = 1'b0;
        if (beat_done) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_data_d;
        end

        beat_cnt_d = beat_cnt_q;
        if (out_valid_q && bus.OutReady && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        rpreset_d = rpreset_q;
        if (bus.Flush) begin
            // Restarts the pointer-reset pulse even when already flushing.
            state_d   = FLUSH;
            fl_cnt_d  = 1'b1;
            rpreset_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE:  if (bus.Enable) state_d = RUN;
                RUN:   if (!bus.Enable) state_d = DRAIN;
                DRAIN: if (!inflight_q) state_d = IDLE;
                FLUSH: begin
                    if (fl_cnt_q) begin
                        fl_cnt_d = 1'b0;
                    end else begin
                        rpreset_d = 1'b0;
                        state_d   = bus.Enable ? RUN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            asm_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            fl_cnt_q    <= 1'b0;
            rpreset_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            asm_cnt_q   <= asm_cnt_d;
            inflight_q  <= inflight_d;
            fl_cnt_q    <= fl_cnt_d;
            rpreset_q   <= rpreset_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Assembly slots are qualified by asm_cnt_q, so they need no reset.
    always_ff @(posedge Clock) begin
        asm_data_q <= asm_data_d;
    end

    assign bus.FifoRdEn    = rd_en;
    assign bus.FifoRPReset = rpreset_q;
    assign bus.OutData     = out_data_q;
    assign bus.OutValid    = out_valid_q;
    assign bus.Busy        = (state_q != IDLE) || inflight_q;
    assign bus.BeatCount   = beat_cnt_q;
endmodule
